fft_out_reorder: RTL and testbench

Downstream stage of the 32-point single-path-delay FFT core. The FFT core emits each frame in bit-reversed index order. This block collects each frame in a ping-pong register buffer and re-emits it in natural order (bin 0 first) to the SNR and golden-compare consumer. It passes sample values through unchanged and adds no arithmetic.

---
 rtl/fft_pkg.sv | 22 ++
 rtl/fft_reorder_bank.sv | 23 ++
 rtl/fft_out_reorder.sv | 98 +++++++++
 tb/tb_fft_out_reorder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: constants, sample type, read FSM states and index bit reversal shared by the FFT core and its output reorder stage.
package fft_pkg;

    localparam int FFT_size  = 32;
    localparam int LOG2_size = 5;
    localparam int IN_width  = 16;
    localparam int OUT_width = 16;

    typedef struct packed {
        logic signed [OUT_width-1:0] r;
        logic signed [OUT_width-1:0] i;
    } sample_t;

    typedef enum logic {IDLE, READ} rd_state_e;

    function automatic logic [LOG2_size-1:0] bitrev(input logic [LOG2_size-1:0] idx);
        logic [LOG2_size-1:0] rev;
        for (int b = 0; b < LOG2_size; b++) rev[b] = idx[LOG2_size-1-b];
        return rev;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// fft_reorder_bank: register-file frame buffer with one synchronous write port and one combinational read port.
module fft_reorder_bank #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int W     = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: ping-pong buffer that turns bit-reversed FFT frames into natural-order output streams.
module fft_out_reorder #(
    parameter int FFT_size  = 32,
    parameter int LOG2_size = 5,
    parameter int OUT_width = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic signed [OUT_width-1:0] din_r,
    input  logic signed [OUT_width-1:0] din_i,
    output logic                        out_valid,
    output logic signed [OUT_width-1:0] dout_r,
    output logic signed [OUT_width-1:0] dout_i
);

    import fft_pkg::*;

    localparam logic [LOG2_size-1:0] LAST = LOG2_size'(FFT_size - 1);

    rd_state_e                state, state_nxt;
    logic [LOG2_size-1:0]     wcnt, rcnt, waddr;
    logic                     wbank, rbank, fire, rlast, wlast;
    logic [1:0]               full;
    logic [2*OUT_width-1:0]   wdata, rdata0, rdata1;

    assign waddr = bitrev(wcnt);
    assign wdata = {din_r, din_i};

    fft_reorder_bank #(.DEPTH(FFT_size), .AW(LOG2_size), .W(2*OUT_width)) u_bank0 (
        .clk   (clk),
        .we    (in_valid && !wbank),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (rcnt),
        .rdata (rdata0)
    );

    fft_reorder_bank #(.DEPTH(FFT_size), .AW(LOG2_size), .W(2*OUT_width)) u_bank1 (
        .clk   (clk),
        .we    (in_valid && wbank),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (rcnt),
        .rdata (rdata1)
    );

    // Bin 0 is emitted straight from IDLE so output starts one edge after the frame completes.
    always_comb begin
        fire      = (state == READ) || full[rbank];
        rlast     = fire && (rcnt == LAST);
        wlast     = in_valid && (wcnt == LAST);
        state_nxt = rlast ? ((full[~rbank] || (wlast && (wbank != rbank))) ? READ : IDLE)
                          : (fire ? READ : state);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt  <= '0;
            wbank <= 1'b0;
        end else if (in_valid) begin
            wcnt <= wcnt + 1'b1;
            if (wlast) wbank <= ~wbank;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 2'b00;
        end else begin
            if (wlast) full[wbank] <= 1'b1;
            if (rlast) full[rbank] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt      <= '0;
            rbank     <= 1'b0;
            out_valid <= 1'b0;
            dout_r    <= '0;
            dout_i    <= '0;
        end else begin
            out_valid <= fire;
            if (fire) begin
                rcnt             <= rcnt + 1'b1;
                {dout_r, dout_i} <= rbank ? rdata1 : rdata0;
            end
            if (rlast) rbank <= ~rbank;
        end
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: directed scenarios for the FFT output reorder buffer with hand-derived natural-order expectations.
module tb_fft_out_reorder;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [15:0] din_r = '0;
    logic signed [15:0] din_i = '0;
    logic               out_valid;
    logic signed [15:0] dout_r;
    logic signed [15:0] dout_i;

    int n_checks = 0;
    int n_fail   = 0;

    fft_out_reorder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .din_r     (din_r),
        .din_i     (din_i),
        .out_valid (out_valid),
        .dout_r    (dout_r),
        .dout_i    (dout_i)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] tb_bitrev(input logic [4:0] k);
        return {k[0], k[1], k[2], k[3], k[4]};
    endfunction

    // Mode 0 is a ramp (value n + offs at bin n); mode 1 is the full-scale alternating frame.
    function automatic logic signed [15:0] exp_r(input int mode, input int n, input int offs);
        if (mode == 0) return 16'(n + offs);
        return (n < 16) ? 16'sh7fff : 16'sh8000;
    endfunction

    function automatic logic signed [15:0] exp_i(input int mode, input int n, input int offs);
        if (mode == 0) return 16'(-(n + offs));
        return (n < 16) ? 16'sh8000 : 16'sh7fff;
    endfunction

    task automatic drive_frame(input int mode, input int offs, input bit gapped, input int count);
        for (int k = 0; k < count; k++) begin
            automatic logic [4:0] br = tb_bitrev(5'(k));
            if (gapped && k > 0) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            in_valid = 1'b1;
            if (mode == 0) begin
                din_r = 16'(int'(br) + offs);
                din_i = 16'(-(int'(br) + offs));
            end else begin
                din_r = (k % 2 == 0) ? 16'sh7fff : 16'sh8000;
                din_i = (k % 2 == 0) ? 16'sh8000 : 16'sh7fff;
            end
        end
    endtask

    task automatic stop_input();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic check_frame(input int mode, input int offs, input int nbins, input string name);
        for (int n = 0; n < nbins; n++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || dout_r !== exp_r(mode, n, offs) || dout_i !== exp_i(mode, n, offs)) begin
                n_fail++;
                $display("FAIL %s bin %0d: got valid=%b r=%0d i=%0d, expected valid=1 r=%0d i=%0d",
                         name, n, out_valid, dout_r, dout_i, exp_r(mode, n, offs), exp_i(mode, n, offs));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || dout_r !== 16'sd0 || dout_i !== 16'sd0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b r=%0d i=%0d, expected 0 0 0", out_valid, dout_r, dout_i);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_ramp();
        drive_frame(0, 0, 1'b0, 32);
        stop_input();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ramp_latency: got valid=%b at last-sample edge, expected 0", out_valid);
        end
        check_frame(0, 0, 32, "ramp");
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || dout_r !== 16'sd31 || dout_i !== -16'sd31) begin
            n_fail++;
            $display("FAIL ramp_hold: got valid=%b r=%0d i=%0d, expected 0 31 -31", out_valid, dout_r, dout_i);
        end
    endtask

    task automatic test_back_to_back();
        fork
            begin
                drive_frame(0, 0, 1'b0, 32);
                drive_frame(0, 100, 1'b0, 32);
                stop_input();
            end
            begin
                repeat (33) @(posedge clk);
                check_frame(0, 0, 32, "b2b_first");
                check_frame(0, 100, 32, "b2b_second");
            end
        join
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got valid=%b after 64 bins, expected 0", out_valid);
        end
    endtask

    task automatic test_gapped();
        drive_frame(0, 0, 1'b1, 32);
        stop_input();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL gapped_latency: got valid=%b at last-sample edge, expected 0", out_valid);
        end
        check_frame(0, 0, 32, "gapped");
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL gapped_end: got valid=%b after 32 bins, expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        automatic bit seen = 1'b0;
        drive_frame(0, 0, 1'b0, 10);
        stop_input();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL midframe_quiet: got out_valid=1 after partial frame, expected 0");
        end
        drive_frame(0, 0, 1'b0, 32);
        stop_input();
        check_frame(0, 0, 32, "after_midframe_reset");
    endtask

    task automatic test_reset_mid_read();
        automatic bit seen = 1'b0;
        @(posedge clk); #1;
        drive_frame(0, 0, 1'b0, 32);
        stop_input();
        check_frame(0, 0, 16, "midread_prefix");
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || dout_r !== 16'sd0 || dout_i !== 16'sd0) begin
            n_fail++;
            $display("FAIL midread_async: got valid=%b r=%0d i=%0d, expected 0 0 0", out_valid, dout_r, dout_i);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL midread_quiet: got out_valid=1 after reset, expected 0");
        end
    endtask

    task automatic test_extremes();
        drive_frame(1, 0, 1'b0, 32);
        stop_input();
        check_frame(1, 0, 32, "extremes");
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL extremes_end: got valid=%b after 32 bins, expected 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_back_to_back();
        test_gapped();
        test_reset_mid_frame();
        test_reset_mid_read();
        test_extremes();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
